// File: rtl/rans_pkg.sv
// Shared constants and state encoding for the rANS decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rans_pkg;

   localparam int STATE_WIDTH = 32;
   localparam int IO_BITS     = 8;
   localparam logic [STATE_WIDTH-1:0] RANS_L = 32'h0080_0000;  // 2^23

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FILL,
      ST_INIT,
      ST_LOOKUP,
      ST_FETCH,
      ST_UPDATE,
      ST_EMIT,
      ST_RENORM,
      ST_DONE
   } rans_dec_state_t;

endpackage

// File: rtl/rans_dec_lut.sv
// Slot-to-symbol lookup RAM, 2^RESOLUTION entries of SYMBOL_WIDTH bits, single port.
// Latency: 1-cycle synchronous read; write and read share the address port.
// Backpressure: none; the caller never writes and reads in the same cycle.
// Ports: clk_i clock; wr_en write strobe; addr slot address; wr_dat symbol to store;
//        rd_dat registered read data for the previous cycle's addr.
module rans_dec_lut #(
   parameter int RESOLUTION   = 10,
   parameter int SYMBOL_WIDTH = 8
) (
   input  logic                    clk_i,
   input  logic                    wr_en,
   input  logic [RESOLUTION-1:0]   addr,
   input  logic [SYMBOL_WIDTH-1:0] wr_dat,
   output logic [SYMBOL_WIDTH-1:0] rd_dat
);

   logic [SYMBOL_WIDTH-1:0] mem [2**RESOLUTION];

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[addr] <= wr_dat;
      end
      rd_dat <= mem[addr];
   end

endmodule

// File: rtl/rans_decoder.sv
// Byte-wise rANS decoder: table load (freq/cum + slot LUT fill), then stream decode.
// Latency: valid_o 3 cycles after LOOKUP; 4 cycles/symbol without renorm or stalls.
// Backpressure: holds EMIT (dec_o stable) while dec_ready_i=0; stalls INIT/RENORM on enc_valid_i=0.
// Ports: clk_i/rst_i clock and sync reset; freq_wr_i/freq_i/cum_freq_i/symb_i table write;
//        start_i/len_i stream start; enc_valid_i/enc_i/enc_ready_o byte input;
//        valid_o/dec_o/dec_ready_i symbol output; ready_o idle; done_o/err_o end-of-stream status.
module rans_decoder
   import rans_pkg::*;
#(
   parameter int RESOLUTION   = 10,
   parameter int SYMBOL_WIDTH = 8,
   parameter int LEN_WIDTH    = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    freq_wr_i,
   input  logic [RESOLUTION-1:0]   freq_i,
   input  logic [RESOLUTION-1:0]   cum_freq_i,
   input  logic [SYMBOL_WIDTH-1:0] symb_i,
   input  logic                    start_i,
   input  logic [LEN_WIDTH-1:0]    len_i,
   input  logic                    enc_valid_i,
   input  logic [IO_BITS-1:0]      enc_i,
   output logic                    enc_ready_o,
   output logic                    ready_o,
   output logic                    valid_o,
   output logic [SYMBOL_WIDTH-1:0] dec_o,
   input  logic                    dec_ready_i,
   output logic                    done_o,
   output logic                    err_o
);

   rans_dec_state_t state_q, state_d;

   logic [STATE_WIDTH-1:0]  x_q;
   logic [LEN_WIDTH-1:0]    cnt_q;
   logic [1:0]              init_cnt_q;
   logic [RESOLUTION-1:0]   fill_k_q, fill_freq_q, fill_cum_q;
   logic [SYMBOL_WIDTH-1:0] fill_sym_q, sym_q;
   logic                    err_q;

   logic [RESOLUTION-1:0]   freq_mem [2**SYMBOL_WIDTH];
   logic [RESOLUTION-1:0]   cum_mem  [2**SYMBOL_WIDTH];
   logic [RESOLUTION-1:0]   freq_rd, cum_rd;

   logic                    lut_we;
   logic [RESOLUTION-1:0]   lut_addr;
   logic [SYMBOL_WIDTH-1:0] lut_rd;

   logic                    byte_fire, fill_last;
   logic [RESOLUTION-1:0]   slot;
   logic [STATE_WIDTH-1:0]  x_shift, x_upd, freq_ext, cum_ext, slot_ext;

   assign byte_fire = enc_valid_i && enc_ready_o;
   assign x_shift   = {x_q[STATE_WIDTH-IO_BITS-1:0], enc_i};
   assign slot      = x_q[RESOLUTION-1:0];
   // Extra top bit so freq = 2^RESOLUTION-1 still terminates and freq = 0 ends after one cycle.
   assign fill_last = ({1'b0, fill_k_q} + (RESOLUTION+1)'(1)) >= {1'b0, fill_freq_q};
   assign lut_we    = (state_q == ST_FILL) && (fill_k_q < fill_freq_q);
   assign lut_addr  = (state_q == ST_FILL) ? (fill_cum_q + fill_k_q) : slot;

   assign freq_ext  = {{(STATE_WIDTH-RESOLUTION){1'b0}}, freq_rd};
   assign cum_ext   = {{(STATE_WIDTH-RESOLUTION){1'b0}}, cum_rd};
   assign slot_ext  = {{(STATE_WIDTH-RESOLUTION){1'b0}}, slot};
   assign x_upd     = freq_ext * (x_q >> RESOLUTION) + slot_ext - cum_ext;

   assign dec_o = sym_q;
   assign err_o = err_q;

   rans_dec_lut #(
      .RESOLUTION  (RESOLUTION),
      .SYMBOL_WIDTH(SYMBOL_WIDTH)
   ) u_lut (
      .clk_i  (clk_i),
      .wr_en  (lut_we),
      .addr   (lut_addr),
      .wr_dat (fill_sym_q),
      .rd_dat (lut_rd)
   );

   always_comb begin
      state_d     = state_q;
      ready_o     = 1'b0;
      valid_o     = 1'b0;
      enc_ready_o = 1'b0;
      done_o      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (freq_wr_i) begin
               state_d = ST_FILL;
            end else if (start_i) begin
               state_d = (len_i == '0) ? ST_DONE : ST_INIT;
            end
         end
         ST_FILL: begin
            if (fill_last) state_d = ST_IDLE;
         end
         ST_INIT: begin
            enc_ready_o = 1'b1;
            if (enc_valid_i && init_cnt_q == 2'd3) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_UPDATE;
         ST_UPDATE: state_d = ST_EMIT;
         ST_EMIT: begin
            valid_o = 1'b1;
            if (dec_ready_i) begin
               // Going straight to LOOKUP when x is already normalised keeps 4 cycles/symbol.
               if (cnt_q == '0)         state_d = ST_DONE;
               else if (x_q < RANS_L)   state_d = ST_RENORM;
               else                     state_d = ST_LOOKUP;
            end
         end
         ST_RENORM: begin
            if (x_q < RANS_L) begin
               enc_ready_o = 1'b1;
               // Look ahead at the shifted value so the last byte leads straight to LOOKUP.
               if (enc_valid_i && x_shift >= RANS_L) state_d = ST_LOOKUP;
            end else begin
               state_d = ST_LOOKUP;
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         cnt_q       <= '0;
         init_cnt_q  <= '0;
         fill_k_q    <= '0;
         fill_freq_q <= '0;
         fill_cum_q  <= '0;
         fill_sym_q  <= '0;
         sym_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (freq_wr_i) begin
                  fill_freq_q <= freq_i;
                  fill_cum_q  <= cum_freq_i;
                  fill_sym_q  <= symb_i;
                  fill_k_q    <= '0;
               end else if (start_i) begin
                  cnt_q      <= len_i;
                  err_q      <= 1'b0;
                  init_cnt_q <= '0;
               end
            end
            ST_FILL: fill_k_q <= fill_k_q + RESOLUTION'(1);
            ST_INIT: begin
               if (byte_fire) begin
                  x_q        <= x_shift;
                  init_cnt_q <= init_cnt_q + 2'd1;
               end
            end
            ST_FETCH: sym_q <= lut_rd;
            ST_UPDATE: begin
               x_q   <= x_upd;
               cnt_q <= cnt_q - LEN_WIDTH'(1);
            end
            ST_EMIT: begin
               if (dec_ready_i && cnt_q == '0) err_q <= (x_q != RANS_L);
            end
            ST_RENORM: begin
               if (byte_fire) x_q <= x_shift;
            end
            default: ;
         endcase
      end
   end

   // Per-symbol frequency and cumulative tables; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (state_q == ST_IDLE && freq_wr_i) begin
         freq_mem[symb_i] <= freq_i;
         cum_mem[symb_i]  <= cum_freq_i;
      end
      if (state_q == ST_FETCH) begin
         freq_rd <= freq_mem[lut_rd];
         cum_rd  <= cum_mem[lut_rd];
      end
   end

endmodule

// File: tb/tb_rans_decoder.sv
// Testbench for rans_decoder: directed stream cases plus randomized tables/messages
// encoded by a behavioural rANS encoder model; checks symbols, bytes, done/err timing.
// Backpressure is exercised on both the byte input and the symbol output.
module tb_rans_decoder;

   localparam int RES = 10;
   localparam int SW  = 8;
   localparam int LW  = 16;
   localparam longint L = 64'd8388608;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          freq_wr_i;
   logic [RES-1:0] freq_i, cum_freq_i;
   logic [SW-1:0] symb_i;
   logic          start_i;
   logic [LW-1:0] len_i;
   logic          enc_valid_i;
   logic [7:0]    enc_i;
   logic          enc_ready_o, ready_o, valid_o, dec_ready_i, done_o, err_o;
   logic [SW-1:0] dec_o;

   int total = 0;
   int bad   = 0;

   logic [7:0] bq[$];
   logic [7:0] exp_syms[$];
   logic [7:0] sym_list[$];
   int tf[256];
   int tc[256];

   always #5 clk_i = ~clk_i;

   rans_decoder #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW), .LEN_WIDTH(LW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .freq_wr_i(freq_wr_i), .freq_i(freq_i), .cum_freq_i(cum_freq_i), .symb_i(symb_i),
      .start_i(start_i), .len_i(len_i),
      .enc_valid_i(enc_valid_i), .enc_i(enc_i), .enc_ready_o(enc_ready_o),
      .ready_o(ready_o), .valid_o(valid_o), .dec_o(dec_o), .dec_ready_i(dec_ready_i),
      .done_o(done_o), .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Write one table entry and count the cycles ready_o stays low.
   task automatic write_entry(input logic [7:0] s, input int f, input int c, input bit poke,
                              output int low);
      freq_wr_i  = 1'b1;
      symb_i     = s;
      freq_i     = RES'(f);
      cum_freq_i = RES'(c);
      step();
      freq_wr_i = 1'b0;
      low = 0;
      while (ready_o === 1'b0 && low < 2000) begin
         low++;
         start_i = poke && (low == 2);
         len_i   = 16'd3;
         step();
      end
      start_i = 1'b0;
   endtask

   // Reference rANS encoder: encodes exp_syms in reverse, emits bytes LSB-first,
   // flushes the state; the decoder reads the emitted bytes in reverse order.
   task automatic encode();
      longint x;
      longint xmax;
      int f;
      logic [7:0] s;
      logic [7:0] emitted[$];
      x = L;
      for (int i = exp_syms.size() - 1; i >= 0; i--) begin
         s = exp_syms[i];
         f = tf[s];
         xmax = ((L >> RES) << 8) * longint'(f);
         while (x >= xmax) begin
            emitted.push_back(8'(x & 255));
            x = x >> 8;
         end
         x = ((x / f) << RES) + (x % f) + longint'(tc[s]);
      end
      for (int i = 0; i < 4; i++) begin
         emitted.push_back(8'(x & 255));
         x = x >> 8;
      end
      bq.delete();
      for (int i = emitted.size() - 1; i >= 0; i--) bq.push_back(emitted[i]);
   endtask

   // rdy_mode: 0 always ready/valid, 1 random gaps both sides, 2 each symbol held 5 cycles.
   task automatic run_stream(input int len, input int rdy_mode, input bit exp_err,
                             input string tag);
      int bi = 0, si = 0, cyc = 0, hold = 0, last_hs = -10;
      bit got_done = 0;
      bit prev_v = 0;
      logic [7:0] prev_d = 8'h00;
      start_i = 1'b1;
      len_i   = LW'(len);
      step();
      start_i = 1'b0;
      while (!got_done && cyc < 5000) begin
         enc_valid_i = (bi < bq.size()) && (rdy_mode != 1 || $urandom_range(0, 3) != 0);
         enc_i       = enc_valid_i ? bq[bi] : 8'($urandom);
         case (rdy_mode)
            0:       dec_ready_i = 1'b1;
            1:       dec_ready_i = ($urandom_range(0, 2) != 0);
            default: dec_ready_i = (hold >= 5);
         endcase
         if (valid_o === 1'b1) begin
            if (prev_v) chk({tag, " dec_o stable"}, dec_o, prev_d);
            chk({tag, " enc_ready in emit"}, enc_ready_o, 1'b0);
            if (dec_ready_i) begin
               if (si < exp_syms.size()) chk({tag, " symbol"}, dec_o, exp_syms[si]);
               else chk({tag, " extra symbol"}, si, exp_syms.size());
               si++;
               prev_v  = 0;
               hold    = 0;
               last_hs = cyc;
            end else begin
               prev_v = 1;
               prev_d = dec_o;
               hold++;
            end
         end else begin
            prev_v = 0;
         end
         if (enc_valid_i && enc_ready_o === 1'b1) bi++;
         if (done_o === 1'b1) begin
            got_done = 1;
            chk({tag, " err_o"}, err_o, exp_err);
            chk({tag, " done after last handshake"}, cyc, last_hs + 1);
         end
         step();
         cyc++;
      end
      enc_valid_i = 1'b0;
      dec_ready_i = 1'b0;
      chk({tag, " done seen"}, got_done, 1'b1);
      chk({tag, " symbols"}, si, len);
      chk({tag, " bytes consumed"}, bi, bq.size());
      chk({tag, " ready after done"}, ready_o, 1'b1);
      chk({tag, " done one pulse"}, done_o, 1'b0);
   endtask

   initial begin
      int low;
      int nsym, rem, cum, f, n;
      logic [7:0] base, s;

      rst_i = 1'b1; freq_wr_i = 1'b0; freq_i = '0; cum_freq_i = '0; symb_i = '0;
      start_i = 1'b0; len_i = '0; enc_valid_i = 1'b0; enc_i = '0; dec_ready_i = 1'b0;
      step();
      step();
      chk("rst ready_o", ready_o, 1'b1);
      chk("rst valid_o", valid_o, 1'b0);
      chk("rst enc_ready_o", enc_ready_o, 1'b0);
      chk("rst done_o", done_o, 1'b0);
      chk("rst err_o", err_o, 1'b0);
      chk("rst dec_o", dec_o, 8'h00);
      rst_i = 1'b0;
      step();

      // Table A: two equiprobable symbols; start during FILL must be ignored.
      write_entry(8'h00, 512, 0, 1'b0, low);
      chk("fill 512 low cycles", low, 512);
      write_entry(8'h01, 512, 512, 1'b1, low);
      chk("fill 512 low cycles (start poked)", low, 512);
      step();
      chk("start in fill ignored ready", ready_o, 1'b1);
      chk("start in fill ignored enc_ready", enc_ready_o, 1'b0);
      write_entry(8'h77, 0, 0, 1'b0, low);
      chk("fill freq0 low cycles", low, 1);

      bq = '{8'h01, 8'h00, 8'h00, 8'h00};
      exp_syms = '{8'h00};
      run_stream(1, 0, 1'b0, "t2");
      bq = '{8'h01, 8'h00, 8'h02, 8'h00};
      exp_syms = '{8'h01};
      run_stream(1, 0, 1'b0, "t1");

      // Reset in the middle of INIT.
      start_i = 1'b1; len_i = 16'd1;
      step();
      start_i = 1'b0;
      enc_valid_i = 1'b1; enc_i = 8'h01;
      step();
      enc_i = 8'h00;
      step();
      enc_valid_i = 1'b0;
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("midinit rst ready_o", ready_o, 1'b1);
      chk("midinit rst valid_o", valid_o, 1'b0);
      chk("midinit rst enc_ready_o", enc_ready_o, 1'b0);
      chk("midinit rst done_o", done_o, 1'b0);
      chk("midinit rst err_o", err_o, 1'b0);
      chk("midinit rst dec_o", dec_o, 8'h00);
      bq = '{8'h01, 8'h00, 8'h02, 8'h00};
      exp_syms = '{8'h01};
      run_stream(1, 0, 1'b0, "t1 rerun");

      // Table B: heavily skewed, final state ends at 2^19 so err_o is raised.
      write_entry(8'h05, 1, 0, 1'b0, low);
      chk("fill freq1 low cycles", low, 1);
      write_entry(8'h06, 1023, 1, 1'b0, low);
      chk("fill freq1023 low cycles", low, 1023);
      bq = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_syms = '{8'h05, 8'h05};
      run_stream(2, 0, 1'b1, "t3");
      run_stream(2, 2, 1'b1, "t3 backpressure");

      // Zero-length stream: done next cycle, no bytes, err cleared.
      enc_valid_i = 1'b1; enc_i = 8'hAA;
      start_i = 1'b1; len_i = 16'd0;
      step();
      start_i = 1'b0;
      chk("len0 done_o", done_o, 1'b1);
      chk("len0 err_o", err_o, 1'b0);
      chk("len0 enc_ready_o", enc_ready_o, 1'b0);
      step();
      chk("len0 ready_o", ready_o, 1'b1);
      chk("len0 done pulse", done_o, 1'b0);
      chk("len0 enc_ready idle", enc_ready_o, 1'b0);
      enc_valid_i = 1'b0;

      // Randomized tables and messages against the encoder model.
      for (int t = 0; t < 3; t++) begin
         nsym = $urandom_range(2, 6);
         base = 8'($urandom);
         rem  = 1024 - 8 * nsym;
         cum  = 0;
         sym_list.delete();
         for (int i = 0; i < nsym; i++) begin
            s = base + 8'(i * 37);
            f = (i == nsym - 1) ? 8 + rem : 8 + $urandom_range(0, rem);
            rem -= f - 8;
            write_entry(s, f, cum, 1'b0, low);
            chk("rand fill low cycles", low, f);
            tf[s] = f;
            tc[s] = cum;
            cum += f;
            sym_list.push_back(s);
         end
         n = $urandom_range(1, 30);
         exp_syms.delete();
         for (int j = 0; j < n; j++) exp_syms.push_back(sym_list[$urandom_range(0, nsym - 1)]);
         encode();
         run_stream(n, (t == 0) ? 0 : 1, 1'b0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
